// File: rtl/count_ones_pkg.sv
// Shared types and helpers for the sequential ones/zeros counter.
// Optional early-exit build is controlled by the COUNT_ONES_EARLY_EXIT_EN macro.
package count_ones_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width able to hold any count from 0 to word_size inclusive.
    function automatic int count_size(input int word_size);
        return $clog2(word_size + 1);
    endfunction

endpackage

// File: rtl/count_ones_par_popcount_chunk.sv
// Combinational population count of one BITS_PER_CYCLE-wide chunk.
module popcount_chunk #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int PC_W           = $clog2(BITS_PER_CYCLE + 1)
) (
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [PC_W-1:0]           ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            ones = ones + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/count_ones_par.sv
// Sequential ones/zeros counter consuming BITS_PER_CYCLE bits per BUSY cycle.
// Define COUNT_ONES_EARLY_EXIT_EN to finish as soon as no counted bits remain.
module count_ones_par
    import count_ones_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int BITS_PER_CYCLE = 1,
    localparam int COUNT_SIZE    = count_size(WORD_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WORD_SIZE-1:0]  data,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_SIZE-1:0] bit_count,
    output state_t                state_dbg
);

    // Handshake: a request is accepted on any rising edge where start=1 and
    // ready=1; start is ignored otherwise. done pulses for exactly one cycle
    // and bit_count then holds until the next accepted request.

    localparam int N     = WORD_SIZE / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W  = $clog2(BITS_PER_CYCLE + 1);

    state_t                 state;
    logic [WORD_SIZE-1:0]   shifter;
    logic [CNT_W-1:0]       chunk_cnt;
    logic [PC_W-1:0]        chunk_ones;
    logic                   last_chunk;

    popcount_chunk #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE),
        .PC_W          (PC_W)
    ) u_popcount (
        .bits(shifter[BITS_PER_CYCLE-1:0]),
        .ones(chunk_ones)
    );

`ifdef COUNT_ONES_EARLY_EXIT_EN
    // The shifter holds only counted bits (inverted in zero mode), so an
    // empty residual means every remaining chunk would add nothing.
    logic [WORD_SIZE-1:0] residual;
    assign residual   = shifter >> BITS_PER_CYCLE;
    assign last_chunk = (chunk_cnt == CNT_W'(N - 1)) || (residual == '0);
`else
    assign last_chunk = (chunk_cnt == CNT_W'(N - 1));
`endif

    assign ready     = (state == IDLE);
    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shifter   <= '0;
            chunk_cnt <= '0;
            bit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shifter   <= mode ? ~data : data;
                        bit_count <= '0;
                        chunk_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    bit_count <= bit_count + COUNT_SIZE'(chunk_ones);
                    shifter   <= shifter >> BITS_PER_CYCLE;
                    chunk_cnt <= chunk_cnt + CNT_W'(1);
                    if (last_chunk) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/count_ones_par.md
Name: count_ones_par

Overview:
Parametrised sequential ones-counter with a start/ready/done handshake and a mode select.
- Accepts a WORD_SIZE-bit word and counts its set bits (or clear bits), BITS_PER_CYCLE bits per clock, using a right-shifting datapath.
- Presents the count with a one-cycle done pulse.
- Drop-in successor for the fixed 4-bit ones-counter in the Chapter 6 datapath/controller examples.

Parameters:
- WORD_SIZE, 8: data word width; must be ≥2.
- BITS_PER_CYCLE, 1: bits consumed per BUSY cycle; must divide WORD_SIZE.
- COUNT_SIZE, $clog2(WORD_SIZE+1): bit_count width. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- mode  input  1  0 = count ones, 1 = count zeros; latched with data.
- data  input  WORD_SIZE  word to count; latched on accepted start.
- ready  output  1  high only in IDLE.
- busy  output  1  high only in BUSY.
- done  output  1  one-cycle pulse; high only in DONE.
- bit_count  output  COUNT_SIZE  result; valid from DONE until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state = IDLE, shifter = 0, chunk counter = 0, bit_count = 0.
  - Outputs: done=0, busy=0, ready=1.
- States are IDLE, BUSY and DONE. ready, busy and done are decoded combinationally from the state register.
- IDLE:
  - If start=1 at edge k: shifter <= (mode ? ~data : data), bit_count <= 0, chunk counter <= 0, go to BUSY.
  - Otherwise hold; bit_count keeps its previous result.
- BUSY, at each edge:
  - bit_count <= bit_count + popcount(shifter[BITS_PER_CYCLE-1:0]).
  - shifter <= shifter >> BITS_PER_CYCLE.
  - chunk counter increments.
  - Go to DONE when the counter reaches N-1, where N = WORD_SIZE/BITS_PER_CYCLE. Early exit is under Optional Feature.
- Base latency: load at edge k, last chunk at edge k+N, done high for the cycle after edge k+N, IDLE (ready=1) after edge k+N+1.
- DONE: unconditionally go to IDLE next edge. start is ignored during DONE.
- start while BUSY or DONE: ignored, no queuing. data and mode changes after acceptance have no effect.
- Arithmetic: the count never exceeds WORD_SIZE, so COUNT_SIZE never overflows. All-ones with WORD_SIZE=8 gives 8 (4'b1000).
- Reset asserted mid-BUSY or mid-DONE: immediate return to IDLE, bit_count=0, no done pulse. The next start is a full fresh operation.
- start held high continuously: back-to-back operations, each accepted on the IDLE cycle. Throughput is one word per N+2 cycles.

Optional Feature:
- Macro: COUNT_ONES_EARLY_EXIT_EN.
- Defined:
  - A BUSY edge also goes to DONE when the post-shift residual (shifter >> BITS_PER_CYCLE) is zero.
  - Latency = index of the highest chunk containing a counted bit + 1, minimum 1 BUSY cycle.
  - data=0 in mode 0 gives one BUSY cycle and count 0.
- Undefined: latency is always N BUSY cycles, independent of data.
- The count result is identical in both builds.

Decomposition:
- Package count_ones_pkg:
  - state typedef (IDLE, BUSY, DONE), 2-bit encoded.
  - Function computing COUNT_SIZE from WORD_SIZE.
- Sub-module popcount_chunk:
  - Combinational popcount of BITS_PER_CYCLE bits, parametrised, output width $clog2(BITS_PER_CYCLE+1).
  - Instantiated once.
- FSM and datapath stay in count_ones_par.

Test Plan (WORD_SIZE=8, BITS_PER_CYCLE=1 unless noted):
- Reset held low 2 cycles, released → ready=1, busy=0, done=0, bit_count=0.
- start with data=8'hB5, mode=0 → busy for 8 cycles, done pulse 1 cycle, bit_count=5, then ready=1. With early exit, also 8 cycles (bit 7 set).
- data=8'h03, mode=0, early exit defined → 2 BUSY cycles, bit_count=2. Macro undefined → 8 cycles, bit_count=2.
- data=8'hF0, mode=1 → bit_count=4. data=8'hFF, mode=0 → bit_count=8. data=8'h00, mode=1 → bit_count=8.
- start asserted on cycle 3 of BUSY with different data → ignored; first result unchanged; bit_count holds after done until the next accept.
- reset pulsed low during BUSY cycle 4 → immediate IDLE, bit_count=0, no done. Next start with 8'h0F → bit_count=4.
- WORD_SIZE=16, BITS_PER_CYCLE=4, data=16'hFFFF → 4 BUSY cycles, bit_count=16 (5'b10000).
